// File: rtl/sdram_cmd_if.sv
`default_nettype none
// ============================================================================
// Module      : sdram_cmd_if
// Description : Command request/handshake bundle between a controller and
//               the SDRAM command issuer.
// Revision    : 1.0 - initial release
// ============================================================================
interface sdram_cmd_if #(
    parameter int AW = 12,
    parameter int BW = 2
);
    logic          cmd_valid;
    logic [3:0]    cmd_type;
    logic [AW-1:0] cmd_addr;
    logic [BW-1:0] cmd_ba;
    logic          cmd_ready;
    logic          cmd_done;

    modport master (
        output cmd_valid, cmd_type, cmd_addr, cmd_ba,
        input  cmd_ready, cmd_done
    );

    modport slave (
        input  cmd_valid, cmd_type, cmd_addr, cmd_ba,
        output cmd_ready, cmd_done
    );
endinterface
`default_nettype wire

// File: rtl/sdram_cmd.sv
`default_nettype none
// ============================================================================
// Module      : sdram_cmd
// Description : Issues one SDRAM command at a time onto registered pins and
//               holds off further requests until its timing window elapses.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_cmd #(
    parameter int CLK_FREQ = 50,
    parameter int AW       = 12,
    parameter int BW       = 2,
    parameter int T_RP     = 20,
    parameter int T_RFC    = 70,
    parameter int T_RCD    = 20,
    parameter int T_MRD    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    sdram_cmd_if.slave    bus,
    output logic          sdram_cke,
    output logic          sdram_cs_n,
    output logic          sdram_ras_n,
    output logic          sdram_cas_n,
    output logic          sdram_we_n,
    output logic [AW-1:0] sdram_addr,
    output logic [BW-1:0] sdram_ba
);
    function automatic int ns_to_cyc(input int t_ns);
        int n;
        n = (t_ns * CLK_FREQ + 999) / 1000;
        return (n < 1) ? 1 : n;
    endfunction

    localparam int N_RP  = ns_to_cyc(T_RP);
    localparam int N_RFC = ns_to_cyc(T_RFC);
    localparam int N_RCD = ns_to_cyc(T_RCD);
    localparam int N_MRD = T_MRD;
    localparam int N_MAX_A = (N_RP > N_RFC) ? N_RP : N_RFC;
    localparam int N_MAX_B = (N_RCD > N_MRD) ? N_RCD : N_MRD;
    localparam int N_MAX   = (N_MAX_A > N_MAX_B) ? N_MAX_A : N_MAX_B;
    localparam int CW      = $clog2(N_MAX + 1);

    localparam logic [3:0] CMD_LMR  = 4'b0000;
    localparam logic [3:0] CMD_REF  = 4'b0001;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_DESL = 4'b1111;

    typedef enum logic [1:0] {
        WAKE = 2'd0,
        IDLE = 2'd1,
        BUSY = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          cke_n;
    logic [3:0]    pins_n;
    logic [AW-1:0] addr_n;
    logic [BW-1:0] ba_n;

    // Counter is preloaded with N-1 so the BUSY window spans exactly N cycles.
    function automatic logic [CW-1:0] wait_load(input logic [3:0] t);
        case (t)
            CMD_PRE: wait_load = CW'(N_RP - 1);
            CMD_REF: wait_load = CW'(N_RFC - 1);
            CMD_LMR: wait_load = CW'(N_MRD - 1);
            CMD_ACT: wait_load = CW'(N_RCD - 1);
            default: wait_load = '0;
        endcase
    endfunction

    // Column commands are not issued by this block; they degrade to NOP.
    function automatic logic [3:0] pin_cmd(input logic [3:0] t);
        case (t)
            CMD_LMR, CMD_REF, CMD_PRE, CMD_ACT, CMD_NOP, CMD_DESL: pin_cmd = t;
            default:                                               pin_cmd = CMD_NOP;
        endcase
    endfunction

    assign bus.cmd_ready = (state == IDLE);
    assign bus.cmd_done  = (state == BUSY) && (cnt == '0);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cke_n   = sdram_cke;
        pins_n  = CMD_NOP;
        addr_n  = sdram_addr;
        ba_n    = sdram_ba;
        case (state)
            WAKE: begin
                cke_n   = 1'b1;
                state_n = IDLE;
            end
            IDLE: begin
                if (bus.cmd_valid) begin
                    pins_n  = pin_cmd(bus.cmd_type);
                    addr_n  = bus.cmd_addr;
                    ba_n    = bus.cmd_ba;
                    cnt_n   = wait_load(bus.cmd_type);
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (cnt != '0) cnt_n = cnt - CW'(1);
                else           state_n = IDLE;
            end
            default: state_n = WAKE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= WAKE;
            cnt        <= '0;
            sdram_cke  <= 1'b0;
            {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= CMD_DESL;
            sdram_addr <= '0;
            sdram_ba   <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            sdram_cke  <= cke_n;
            {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= pins_n;
            sdram_addr <= addr_n;
            sdram_ba   <= ba_n;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_sdram_cmd.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_cmd
// Description : Directed bench for sdram_cmd with a cycle-window reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_cmd;
    localparam int CLK_FREQ = 50;
    localparam int AW = 12;
    localparam int BW = 2;
    localparam int T_RP = 20;
    localparam int T_RFC = 70;
    localparam int T_RCD = 20;
    localparam int T_MRD = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    sdram_cmd_if #(.AW(AW), .BW(BW)) bus();

    logic          cke, cs_n, ras_n, cas_n, we_n;
    logic [AW-1:0] addr;
    logic [BW-1:0] ba;
    logic [3:0]    pins;
    assign pins = {cs_n, ras_n, cas_n, we_n};

    sdram_cmd #(
        .CLK_FREQ(CLK_FREQ), .AW(AW), .BW(BW),
        .T_RP(T_RP), .T_RFC(T_RFC), .T_RCD(T_RCD), .T_MRD(T_MRD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .sdram_cke  (cke),
        .sdram_cs_n (cs_n),
        .sdram_ras_n(ras_n),
        .sdram_cas_n(cas_n),
        .sdram_we_n (we_n),
        .sdram_addr (addr),
        .sdram_ba   (ba)
    );

    // Stimulus: either directly driven, or a command list with valid tied to ready
    logic          drv_valid = 1'b0;
    logic [3:0]    drv_type  = 4'b0111;
    logic [AW-1:0] drv_addr  = '0;
    logic [BW-1:0] drv_ba    = '0;
    logic          tie       = 1'b0;
    logic [3:0]    seq_type [8];
    logic [AW-1:0] seq_addr [8];
    logic [2:0]    seq_idx = 3'd0;
    logic [2:0]    seq_len = 3'd0;

    assign bus.cmd_valid = tie ? (bus.cmd_ready && (seq_idx < seq_len)) : drv_valid;
    assign bus.cmd_type  = tie ? seq_type[seq_idx] : drv_type;
    assign bus.cmd_addr  = tie ? seq_addr[seq_idx] : drv_addr;
    assign bus.cmd_ba    = tie ? 2'd0 : drv_ba;

    always @(posedge clk) if (tie && bus.cmd_valid && bus.cmd_ready) seq_idx <= seq_idx + 3'd1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_q[$];
    int acc_q[$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (rst_n && bus.cmd_valid && bus.cmd_ready) acc_q.push_back(cyc);
    always @(negedge clk) if (bus.cmd_done === 1'b1) done_q.push_back(cyc);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int ns_cyc(input int t_ns);
        real r;
        int  n;
        r = real'(t_ns) * real'(CLK_FREQ) / 1000.0;
        n = int'($ceil(r));
        return (n < 1) ? 1 : n;
    endfunction

    function automatic int window_of(input logic [3:0] t);
        if (t == 4'b0010) return ns_cyc(T_RP);
        if (t == 4'b0001) return ns_cyc(T_RFC);
        if (t == 4'b0000) return T_MRD;
        if (t == 4'b0011) return ns_cyc(T_RCD);
        return 1;
    endfunction

    function automatic logic [3:0] issued_as(input logic [3:0] t);
        if (t[3]) return (t == 4'b1111) ? 4'b1111 : 4'b0111;
        if (t == 4'b0100 || t == 4'b0101 || t == 4'b0110) return 4'b0111;
        return t;
    endfunction

    int            m_left = 0;
    logic          m_cke  = 1'b0;
    logic [3:0]    m_pins = 4'hF;
    logic [AW-1:0] m_addr = '0;
    logic [BW-1:0] m_ba   = '0;

    // m_left counts remaining cycles of the current command's window
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0; m_cke <= 1'b0; m_pins <= 4'hF; m_addr <= '0; m_ba <= '0;
        end else if (!m_cke) begin
            m_cke <= 1'b1; m_pins <= 4'h7;
        end else if (m_left == 0 && bus.cmd_valid) begin
            m_pins <= issued_as(bus.cmd_type);
            m_addr <= bus.cmd_addr;
            m_ba   <= bus.cmd_ba;
            m_left <= window_of(bus.cmd_type);
        end else begin
            m_pins <= 4'h7;
            if (m_left > 0) m_left <= m_left - 1;
        end
    end

    always @(negedge clk) begin
        chk("m_pins",  32'(pins),          32'(m_pins));
        chk("m_addr",  32'(addr),          32'(m_addr));
        chk("m_ba",    32'(ba),            32'(m_ba));
        chk("m_cke",   32'(cke),           32'(m_cke));
        chk("m_ready", 32'(bus.cmd_ready), 32'(m_cke && m_left == 0));
        chk("m_done",  32'(bus.cmd_done),  32'(m_left == 1));
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int low, dcyc, base, abase, got;
        seq_type[0] = 4'b0000; seq_addr[0] = 12'h022;
        seq_type[1] = 4'b0010; seq_addr[1] = 12'h400;
        seq_type[2] = 4'b0001; seq_addr[2] = 12'h000;
        seq_type[3] = 4'b0001; seq_addr[3] = 12'h000;
        seq_type[4] = 4'b0000; seq_addr[4] = 12'h022;
        for (int i = 5; i < 8; i++) begin seq_type[i] = 4'b0111; seq_addr[i] = '0; end

        repeat (2) @(negedge clk);
        #1;
        chk("rst_cke",   32'(cke),           32'd0);
        chk("rst_pins",  32'(pins),          32'hF);
        chk("rst_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rst_done",  32'(bus.cmd_done),  32'd0);
        rst_n = 1'b1;
        step();
        chk("wake_cke",   32'(cke),           32'd1);
        chk("wake_ready", 32'(bus.cmd_ready), 32'd1);
        chk("wake_pins",  32'(pins),          32'h7);

        // PRECHARGE all banks
        drv_valid = 1'b1; drv_type = 4'b0010; drv_addr = 12'h400; drv_ba = 2'd1;
        step();
        drv_valid = 1'b0;
        chk("pre_pins",  32'(pins),          32'h2);
        chk("pre_addr",  32'(addr),          32'h400);
        chk("pre_done",  32'(bus.cmd_done),  32'd1);
        chk("pre_ready", 32'(bus.cmd_ready), 32'd0);
        step();
        chk("pre_ready_after", 32'(bus.cmd_ready), 32'd1);
        chk("pre_addr_hold",   32'(addr),          32'h400);

        // REFRESH
        drv_valid = 1'b1; drv_type = 4'b0001; drv_addr = '0; drv_ba = '0;
        step();
        drv_valid = 1'b0;
        chk("ref_pins", 32'(pins), 32'h1);
        low = 0; dcyc = 0;
        for (int i = 1; i <= 8; i++) begin
            if (!bus.cmd_ready) low++;
            if (bus.cmd_done && dcyc == 0) dcyc = i;
            if (i == 2) chk("ref_pins_nop", 32'(pins), 32'h7);
            if (i < 8) step();
        end
        chk("ref_done_cycle", 32'(dcyc), 32'd4);
        chk("ref_ready_low",  32'(low),  32'd4);

        // LMR
        drv_valid = 1'b1; drv_type = 4'b0000; drv_addr = 12'h022;
        step();
        drv_valid = 1'b0;
        chk("lmr_pins",  32'(pins),         32'h0);
        chk("lmr_addr",  32'(addr),         32'h022);
        chk("lmr_done1", 32'(bus.cmd_done), 32'd0);
        step();
        chk("lmr_done2", 32'(bus.cmd_done), 32'd1);
        step();

        // Init sequence with valid tied to ready
        base = done_q.size();
        seq_len = 3'd5;
        tie = 1'b1;
        for (int i = 0; i < 60 && done_q.size() < base + 5; i++) step();
        chk("seq_dones", 32'(done_q.size() - base), 32'd5);
        if (done_q.size() >= base + 5) begin
            chk("seq_gap_pre",  32'(done_q[base+1] - done_q[base]),   32'd2);
            chk("seq_gap_ref1", 32'(done_q[base+2] - done_q[base+1]), 32'd5);
            chk("seq_gap_ref2", 32'(done_q[base+3] - done_q[base+2]), 32'd5);
            chk("seq_gap_lmr",  32'(done_q[base+4] - done_q[base+3]), 32'd3);
        end
        step();
        tie = 1'b0;
        step();

        // Reset during the second BUSY cycle of REFRESH
        drv_valid = 1'b1; drv_type = 4'b0001; drv_addr = 12'h0AB; drv_ba = 2'd2;
        step();
        drv_valid = 1'b0;
        base = done_q.size();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_pins",  32'(pins),          32'hF);
        chk("mid_rst_cke",   32'(cke),           32'd0);
        chk("mid_rst_addr",  32'(addr),          32'd0);
        chk("mid_rst_ready", 32'(bus.cmd_ready), 32'd0);
        chk("mid_rst_done",  32'(bus.cmd_done),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) step();
        chk("mid_rst_no_done", 32'(done_q.size() - base), 32'd0);
        chk("mid_rst_ready_back", 32'(bus.cmd_ready), 32'd1);

        // READ held high: issued as NOP, accepted every other cycle
        abase = acc_q.size();
        base  = done_q.size();
        drv_valid = 1'b1; drv_type = 4'b0101; drv_addr = 12'h123; drv_ba = 2'd2;
        step();
        chk("read_pins", 32'(pins),         32'h7);
        chk("read_addr", 32'(addr),         32'h123);
        chk("read_done", 32'(bus.cmd_done), 32'd1);
        repeat (7) step();
        drv_valid = 1'b0;
        repeat (2) step();
        got = acc_q.size() - abase;
        chk("read_accepts", 32'(got), 32'd4);
        chk("read_dones",   32'(done_q.size() - base), 32'd4);
        if (got >= 2) chk("read_acc_gap", 32'(acc_q[abase+1] - acc_q[abase]), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
